// File: rtl/gp_vertex_feeder.sv
// Graphics-pipeline front end: double-buffered transform/camera operands plus a
// vertex FIFO, streamed as one {operands, vertex} beat per vertex for a framed count.
module gp_vertex_feeder #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 12
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_n,
    input  logic                      i_ParWe,
    input  logic [3:0]                i_ParAddr,
    input  logic [DATA_W-1:0]         i_ParData,
    input  logic                      i_Start,
    input  logic [CNT_W-1:0]          i_VtxCount,
    input  logic                      i_Abort,
    input  logic                      i_VtxValid,
    output logic                      o_VtxReady,
    input  logic [3*DATA_W-1:0]       i_Vertex,
    output logic                      o_OutValid,
    input  logic                      i_OutReady,
    output logic [16*DATA_W-1:0]      o_OutParams,
    output logic [3*DATA_W-1:0]       o_OutVertex,
    output logic                      o_Busy,
    output logic                      o_Done,
    output logic [$clog2(DEPTH):0]    o_Level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned VTX_W = 3 * DATA_W;
    localparam int unsigned NPAR  = 16;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  shadow_q [NPAR];
    logic [DATA_W-1:0]  shadow_d [NPAR];
    logic [DATA_W-1:0]  active_q [NPAR];
    logic [DATA_W-1:0]  active_d [NPAR];
    logic [VTX_W-1:0]   mem_q [DEPTH];
    logic [VTX_W-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic               push, pop, out_valid;

    // Every output is a direct decode of registered state.
    assign out_valid   = (state_q == ST_RUN) && (level_q != '0);
    assign o_OutValid  = out_valid;
    assign o_VtxReady  = (level_q != LVL_W'(DEPTH));
    assign o_Level     = level_q;
    assign o_OutVertex = mem_q[rd_q];
    assign o_Busy      = (state_q == ST_RUN);
    assign o_Done      = (state_q == ST_DONE);

    always_comb begin
        for (int i = 0; i < NPAR; i++) begin
            o_OutParams[i*DATA_W +: DATA_W] = active_q[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        mem_d    = mem_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        remain_d = remain_q;
        push     = i_VtxValid && o_VtxReady;
        pop      = out_valid && i_OutReady;

        if (i_ParWe) begin
            shadow_d[i_ParAddr] = i_ParData;
        end
        if (push) begin
            mem_d[wr_q] = i_Vertex;
            wr_d        = wr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        level_d = level_q + LVL_W'(push) - LVL_W'(pop);

        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    // Commit includes a same-cycle operand write.
                    remain_d = i_VtxCount;
                    active_d = shadow_d;
                    state_d  = (i_VtxCount == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_Abort) begin
                    state_d = ST_IDLE;
                    wr_d    = '0;
                    rd_d    = '0;
                    level_d = '0;
                end else if (pop) begin
                    remain_d = remain_q - CNT_W'(1);
                    if (remain_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= ST_IDLE;
            wr_q     <= '0;
            rd_q     <= '0;
            level_q  <= '0;
            remain_q <= '0;
            for (int i = 0; i < NPAR; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            level_q  <= level_d;
            remain_q <= remain_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: tb/tb_gp_vertex_feeder.sv
// Directed self-checking bench for gp_vertex_feeder; outputs sampled and inputs
// driven on the falling clock edge.
module tb_gp_vertex_feeder;
    logic         clk;
    logic         rst_n;
    logic         par_we;
    logic [3:0]   par_addr;
    logic [15:0]  par_data;
    logic         start;
    logic [11:0]  vtx_count;
    logic         abort_i;
    logic         vtx_valid;
    logic         vtx_ready;
    logic [47:0]  vertex;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_params;
    logic [47:0]  out_vertex;
    logic         busy;
    logic         done;
    logic [3:0]   level;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [15:0]  pv [16];
    logic [47:0]  vin [40];
    int           in_idx = 0;
    int           in_n = 0;
    int           out_idx = 0;

    gp_vertex_feeder dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_ParWe(par_we), .i_ParAddr(par_addr),
        .i_ParData(par_data), .i_Start(start), .i_VtxCount(vtx_count),
        .i_Abort(abort_i), .i_VtxValid(vtx_valid), .o_VtxReady(vtx_ready),
        .i_Vertex(vertex), .o_OutValid(out_valid), .i_OutReady(out_ready),
        .o_OutParams(out_params), .o_OutVertex(out_vertex), .o_Busy(busy),
        .o_Done(done), .o_Level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] exp_params();
        logic [255:0] r;
        for (int i = 0; i < 16; i++) r[i*16 +: 16] = pv[i];
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic feed();
        if (in_idx < in_n) begin
            vtx_valid = 1'b1;
            vertex    = vin[in_idx];
            if (vtx_ready) in_idx++;
        end else begin
            vtx_valid = 1'b0;
        end
    endtask

    task automatic offer(input int n, input int cycles);
        in_n += n;
        for (int c = 0; c < cycles; c++) begin
            feed();
            step();
        end
        vtx_valid = 1'b0;
    endtask

    // Starts a frame and consumes it, optionally stalling on alternate cycles.
    task automatic run_frame(input int cnt, input bit toggle);
        int beats = 0;
        int cyc = 0;
        bit rdy_ph = 1'b1;
        bit stalled = 1'b0;
        logic [47:0] held = '0;
        start = 1'b1;
        vtx_count = 12'(cnt);
        feed();
        step();
        start = 1'b0;
        while (beats < cnt && cyc < 200) begin
            feed();
            out_ready = toggle ? rdy_ph : 1'b1;
            rdy_ph = ~rdy_ph;
            if (stalled) begin
                check("stall_valid", 256'(out_valid), 256'(1'b1));
                check("stall_hold", 256'(out_vertex), 256'(held));
            end
            stalled = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    check("beat_vertex", 256'(out_vertex), 256'(vin[out_idx]));
                    out_idx++;
                    beats++;
                end else begin
                    held = out_vertex;
                    stalled = 1'b1;
                end
            end
            step();
            cyc++;
        end
        vtx_valid = 1'b0;
        if (cyc >= 200) check("frame_timeout", 256'(beats), 256'(cnt));
        check("done_pulse", 256'(done), 256'(1'b1));
        check("done_busy", 256'(busy), 256'(1'b0));
        check("done_valid", 256'(out_valid), 256'(1'b0));
    endtask

    initial begin
        pv = '{16'hC799, 16'hC300, 16'h4E40, 16'h3800, 16'h3C00, 16'h3C00, 16'h3AED, 16'h0000,
               16'h0000, 16'h4000, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h4900, 16'h4700};
        vin[0] = {16'hC500, 16'h4780, 16'hCD40};
        for (int i = 1; i < 40; i++) vin[i] = {16'(i * 7 + 3), 16'(i * 5 + 2), 16'(i * 3 + 1)};
        rst_n = 1'b0; par_we = 1'b0; par_addr = '0; par_data = '0; start = 1'b0;
        vtx_count = '0; abort_i = 1'b0; vtx_valid = 1'b0; vertex = '0; out_ready = 1'b0;

        #12;
        check("rst_level", 256'(level), 256'(0));
        check("rst_ready", 256'(vtx_ready), 256'(1'b1));
        check("rst_valid", 256'(out_valid), 256'(1'b0));
        check("rst_busy", 256'(busy), 256'(1'b0));
        check("rst_done", 256'(done), 256'(1'b0));
        check("rst_params", out_params, 256'(0));
        check("rst_vertex", 256'(out_vertex), 256'(0));
        step();
        rst_n = 1'b1;
        step();

        // Single-vertex frame with the full operand set.
        for (int i = 0; i < 16; i++) begin
            par_we = 1'b1; par_addr = 4'(i); par_data = pv[i];
            step();
        end
        par_we = 1'b0;
        check("params_uncommitted", out_params, 256'(0));
        offer(1, 1);
        check("t1_level", 256'(level), 256'(1));
        run_frame(1, 1'b0);
        check("t1_params", out_params, exp_params());
        check("t1_level_done", 256'(level), 256'(0));
        step();
        check("t1_done_once", 256'(done), 256'(1'b0));

        // Fill past capacity while idle, then drain ten beats in order.
        offer(10, 12);
        check("t2_ready_full", 256'(vtx_ready), 256'(1'b0));
        check("t2_level_full", 256'(level), 256'(8));
        run_frame(10, 1'b0);
        check("t2_level_done", 256'(level), 256'(0));
        step();

        // Stalling consumer.
        offer(4, 4);
        run_frame(4, 1'b1);
        step();
        check("t3_idle_valid", 256'(out_valid), 256'(1'b0));

        // Operand rewrite mid-frame is deferred to the next start.
        offer(1, 1);
        out_ready = 1'b0;
        start = 1'b1; vtx_count = 12'd1;
        step();
        start = 1'b0;
        check("t4_busy", 256'(busy), 256'(1'b1));
        par_we = 1'b1; par_addr = 4'd0; par_data = 16'h0000;
        step();
        par_we = 1'b0;
        check("t4_params_frozen", out_params, exp_params());
        check("t4_vertex", 256'(out_vertex), 256'(vin[out_idx]));
        out_ready = 1'b1;
        step();
        out_idx++;
        check("t4_done", 256'(done), 256'(1'b1));
        step();
        check("t4_params_still", out_params, exp_params());

        // Zero-count frame, with a write in the start cycle.
        pv[0] = 16'h0000;
        pv[1] = 16'h1234;
        par_we = 1'b1; par_addr = 4'd1; par_data = 16'h1234;
        start = 1'b1; vtx_count = 12'd0;
        step();
        par_we = 1'b0; start = 1'b0;
        check("t5_done", 256'(done), 256'(1'b1));
        check("t5_valid", 256'(out_valid), 256'(1'b0));
        check("t5_params_new", out_params, exp_params());
        step();
        check("t5_done_once", 256'(done), 256'(1'b0));

        // Abort after two of five beats.
        offer(5, 5);
        check("t6_level", 256'(level), 256'(5));
        out_ready = 1'b1;
        start = 1'b1; vtx_count = 12'd5;
        step();
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            check("t6_beat", 256'(out_vertex), 256'(vin[out_idx]));
            out_idx++;
            step();
        end
        check("t6_level_mid", 256'(level), 256'(3));
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        out_idx = in_idx;
        check("t6_busy", 256'(busy), 256'(1'b0));
        check("t6_valid", 256'(out_valid), 256'(1'b0));
        check("t6_level_flush", 256'(level), 256'(0));
        check("t6_no_done", 256'(done), 256'(1'b0));
        step();
        check("t6_no_done_late", 256'(done), 256'(1'b0));

        // Asynchronous reset mid-frame.
        offer(2, 2);
        out_ready = 1'b0;
        start = 1'b1; vtx_count = 12'd2;
        step();
        start = 1'b0;
        check("t7_busy", 256'(busy), 256'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        check("t7_busy_rst", 256'(busy), 256'(1'b0));
        check("t7_valid_rst", 256'(out_valid), 256'(1'b0));
        check("t7_level_rst", 256'(level), 256'(0));
        check("t7_params_rst", out_params, 256'(0));
        check("t7_vertex_rst", 256'(out_vertex), 256'(0));
        step();
        rst_n = 1'b1;
        out_idx = in_idx;
        step();
        check("t7_ready_after", 256'(vtx_ready), 256'(1'b1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gp_vertex_feeder.md
Name: gp_vertex_feeder

Overview:
- Sequential front end for the graphics pipeline. Holds the per-object transform/camera operands (translation, roll/pitch/yaw cos and sin, scale, camera position, camera distance) in a double-buffered register file.
- Buffers incoming vertices in a FIFO and streams one {operand bundle, vertex} beat per vertex to the pipeline under valid/ready, for a programmed vertex count per frame.
- Generalises the flat 16-bit operand set to a parametrised word width, FIFO depth and frame length.

Parameters:
- DATA_W, 16, width of each operand word (16 = half-precision).
- DEPTH, 8, vertex FIFO entries (power of two, >= 2).
- CNT_W, 12, width of the frame vertex count.

Ports:
- i_Clk  in  1  clock, rising edge.
- i_Rst_n  in  1  reset, asynchronous, active-low.
- i_ParWe  in  1  operand write strobe.
- i_ParAddr  in  4  operand index: 0 TranslX, 1 TranslY, 2 TranslZ, 3 CosRoll, 4 CosPitch, 5 CosYaw, 6 SenRoll, 7 SenPitch, 8 SenYaw, 9 ScaleX, 10 ScaleY, 11 ScaleZ, 12 CamVerX, 13 CamVerY, 14 CamVerZ, 15 CamDc.
- i_ParData  in  DATA_W  operand write data.
- i_Start  in  1  frame start pulse.
- i_VtxCount  in  CNT_W  vertices in the frame, sampled with i_Start.
- i_Abort  in  1  abort current frame.
- i_VtxValid  in  1  input vertex valid.
- o_VtxReady  out  1  input vertex ready (= FIFO not full).
- i_Vertex  in  3*DATA_W  {Z,Y,X}, X in LSBs.
- o_OutValid  out  1  output beat valid.
- i_OutReady  in  1  downstream ready.
- o_OutParams  out  16*DATA_W  active operand bank, index 0 in LSBs.
- o_OutVertex  out  3*DATA_W  FIFO head vertex.
- o_Busy  out  1  frame in progress.
- o_Done  out  1  one-cycle frame-complete pulse.
- o_Level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (asynchronous, active-low) clears:
  - both operand banks and FIFO pointers, so o_Level = 0 and o_VtxReady = 1;
  - the remaining count;
  - o_OutValid, o_Busy, o_Done, o_OutParams and o_OutVertex (all 0).
  - FSM goes to IDLE. Reset asserted mid-frame drops the frame and any buffered vertices.
- Operand writes:
  - i_ParWe writes the shadow bank in any state, taking effect the following cycle.
  - The active bank copies the whole shadow bank only when i_Start is accepted in IDLE.
  - A write in the same cycle as an accepted start commits the new value to the active bank.
  - o_OutParams is constant for the entire frame.
- FIFO:
  - Push when i_VtxValid && o_VtxReady, in any state.
  - Pop when o_OutValid && i_OutReady.
  - Push and pop in the same cycle leave o_Level unchanged. Push while full is impossible because ready is low.
  - No bypass: a vertex pushed in cycle N can be output at N+1 at the earliest.
  - Pointers wrap modulo DEPTH.
- FSM IDLE: o_Busy = 0 and o_OutValid = 0. On i_Start, latch the count, commit the operand bank and go to:
  - DONE if the count is 0;
  - RUN otherwise.
- FSM RUN:
  - o_Busy = 1.
  - o_OutValid = (o_Level != 0). o_OutVertex is the FIFO head, which must stay stable while valid and not ready.
  - Each accepted beat decrements the remaining count. Accepting the beat at remaining = 1 moves the FSM to DONE.
  - i_Start is ignored in RUN.
  - i_Abort moves the FSM to IDLE next cycle, flushes the FIFO (o_Level = 0) and suppresses o_Done.
  - Abort has priority over a simultaneous final handshake.
- FSM DONE: o_Done = 1 for exactly one cycle, o_Busy = 0, then IDLE.
  - Vertices beyond the frame count remain in the FIFO for the next frame.
- i_Abort in IDLE or DONE has no effect.
- Handshake: o_OutValid never deasserts without a transfer, except on abort or reset.

Test Plan:
- Write 16 operands (TranslX = 16'hC799, TranslY = 16'hC300, TranslZ = 16'h4E40, CosRoll = 16'h3800, SenRoll = 16'h3AED, ..., CamDc = 16'h4700), push vertex {16'hC500, 16'h4780, 16'hCD40}, start with count = 1, OutReady = 1 -> o_OutParams equals the written values; one beat carries that vertex; o_Done pulses one cycle after the handshake; o_Busy falls.
- DEPTH = 8: push 10 vertices while IDLE -> o_VtxReady low after 8, o_Level = 8; start count = 10 -> 10 beats in push order; o_Level is 0 at done.
- Count = 4, OutReady toggling 1,0,1,0 -> o_OutVertex stable during stalls; exactly 4 beats; done after the 4th.
- During RUN, rewrite TranslX to 16'h0000 -> o_OutParams unchanged until the next start, then shows 16'h0000.
- Start with count = 0 -> o_Done the next cycle, no o_OutValid.
- Abort after 2 of 5 beats with 3 vertices buffered -> IDLE, o_Level = 0, no o_Done. Reset asserted mid-frame -> all outputs 0 asynchronously.
